// File: rtl/vx_om_req_arb.sv
// Round-robin arbiter funnelling OM requests from several sources
// into one OM unit through a two-entry head/skid output buffer.
module vx_om_req_arb #(
  parameter int NUM_REQS   = 4,
  parameter int DATA_WIDTH = 128,
  parameter int PERF_WIDTH = 32,
  parameter int IDX_W      = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [NUM_REQS-1:0]            req_valid_in,
  input  logic [NUM_REQS*DATA_WIDTH-1:0] req_data_in,
  output logic [NUM_REQS-1:0]            req_ready_in,
  output logic                           req_valid_out,
  output logic [DATA_WIDTH-1:0]          req_data_out,
  output logic [IDX_W-1:0]               req_sel_out,
  input  logic                           req_ready_out,
  output logic [PERF_WIDTH-1:0]          perf_stalls_out
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t                state_q;
  state_t                state_d;
  logic [IDX_W-1:0]      rr_ptr;
  logic [DATA_WIDTH-1:0] head_data;
  logic [IDX_W-1:0]      head_sel;
  logic [DATA_WIDTH-1:0] skid_data;
  logic [IDX_W-1:0]      skid_sel;
  logic [PERF_WIDTH-1:0] stalls_q;

  logic                  accept;
  logic                  grant_vld;
  logic [IDX_W-1:0]      grant_idx;
  logic [IDX_W:0]        k;
  logic [DATA_WIDTH-1:0] grant_data;
  logic                  push;
  logic                  pop;
  logic                  ld_head_new;
  logic                  ld_head_skid;
  logic                  ld_skid_new;

  assign accept = (state_q != FULL) && reset_n;

  // search starts at rr_ptr and wraps past the last source
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    k         = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      k = {1'b0, rr_ptr} + (IDX_W+1)'(i);
      if (k >= (IDX_W+1)'(NUM_REQS))
        k = k - (IDX_W+1)'(NUM_REQS);
      if (!grant_vld && req_valid_in[k[IDX_W-1:0]]) begin
        grant_vld = 1'b1;
        grant_idx = k[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    req_ready_in = '0;
    if (accept && grant_vld)
      req_ready_in[grant_idx] = 1'b1;
  end

  assign grant_data    = req_data_in[grant_idx*DATA_WIDTH +: DATA_WIDTH];
  assign push          = accept && grant_vld;
  assign req_valid_out = (state_q != EMPTY);
  assign pop           = req_valid_out && req_ready_out;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      state_q <= EMPTY;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    ld_head_new  = 1'b0;
    ld_head_skid = 1'b0;
    ld_skid_new  = 1'b0;
    unique case (state_q)
      EMPTY: begin
        if (push) begin
          state_d     = ONE;
          ld_head_new = 1'b1;
        end
      end
      ONE: begin
        if (push && pop) begin
          ld_head_new = 1'b1;
        end else if (push) begin
          state_d     = FULL;
          ld_skid_new = 1'b1;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          state_d      = ONE;
          ld_head_skid = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_data <= '0;
      head_sel  <= '0;
      skid_data <= '0;
      skid_sel  <= '0;
    end else begin
      if (ld_head_new) begin
        head_data <= grant_data;
        head_sel  <= grant_idx;
      end else if (ld_head_skid) begin
        head_data <= skid_data;
        head_sel  <= skid_sel;
      end
      if (ld_skid_new) begin
        skid_data <= grant_data;
        skid_sel  <= grant_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      rr_ptr <= '0;
    else if (push)
      rr_ptr <= (grant_idx == IDX_W'(NUM_REQS-1)) ? '0 : grant_idx + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      stalls_q <= '0;
    else if (req_valid_out && !req_ready_out && (stalls_q != '1))
      stalls_q <= stalls_q + 1'b1;
  end

  assign req_data_out    = head_data;
  assign req_sel_out     = head_sel;
  assign perf_stalls_out = stalls_q;

endmodule

// File: tb/tb_vx_om_req_arb.sv
// Bench for vx_om_req_arb: queue model of the buffer plus
// directed scenarios and a randomized soak with async resets.
module tb_vx_om_req_arb;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [N-1:0]    req_valid_in;
  logic [N*DW-1:0] req_data_in;
  logic [N-1:0]    req_ready_in;
  logic            req_valid_out;
  logic [DW-1:0]   req_data_out;
  logic [IW-1:0]   req_sel_out;
  logic            req_ready_out;
  logic [31:0]     perf_stalls_out;

  logic [N-1:0]    rdy4;
  logic            vo4;
  logic [DW-1:0]   do4;
  logic [IW-1:0]   so4;
  logic [3:0]      perf4;

  always #5 clk = ~clk;

  vx_om_req_arb #(.NUM_REQS(N), .DATA_WIDTH(DW), .PERF_WIDTH(32)) u_dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid_in(req_valid_in), .req_data_in(req_data_in),
    .req_ready_in(req_ready_in), .req_valid_out(req_valid_out),
    .req_data_out(req_data_out), .req_sel_out(req_sel_out),
    .req_ready_out(req_ready_out), .perf_stalls_out(perf_stalls_out)
  );

  vx_om_req_arb #(.NUM_REQS(N), .DATA_WIDTH(DW), .PERF_WIDTH(4)) u_dut4 (
    .clk(clk), .reset_n(reset_n),
    .req_valid_in(req_valid_in), .req_data_in(req_data_in),
    .req_ready_in(rdy4), .req_valid_out(vo4),
    .req_data_out(do4), .req_sel_out(so4),
    .req_ready_out(req_ready_out), .perf_stalls_out(perf4)
  );

  int n_chk  = 0;
  int n_fail = 0;

  logic [DW-1:0] q_data[$];
  int            q_sel[$];
  int            rr;
  int            stalls;
  int            m_grant;
  bit            m_pop;

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    q_data.delete();
    q_sel.delete();
    rr     = 0;
    stalls = 0;
  endtask

  task automatic compare();
    int g;
    int kk;
    logic [N-1:0] er;
    g = -1;
    for (int i = 0; i < N; i++) begin
      kk = (rr + i) % N;
      if (g < 0 && req_valid_in[kk]) g = kk;
    end
    er = '0;
    if (q_data.size() < 2 && g >= 0) er[g] = 1'b1;
    chk("ready_in", 64'(req_ready_in), 64'(er));
    chk("ready_in_p4", 64'(rdy4), 64'(er));
    chk("valid_out", 64'(req_valid_out), 64'(q_data.size() > 0));
    chk("valid_out_p4", 64'(vo4), 64'(q_data.size() > 0));
    if (q_data.size() > 0) begin
      chk("data_out", 64'(req_data_out), 64'(q_data[0]));
      chk("sel_out", 64'(req_sel_out), 64'(q_sel[0]));
    end
    chk("perf", 64'(perf_stalls_out), 64'(stalls));
    chk("perf_sat4", 64'(perf4), 64'((stalls > 15) ? 15 : stalls));
    m_grant = (er != '0) ? g : -1;
    m_pop   = (q_data.size() > 0) && req_ready_out;
  endtask

  task automatic model_update();
    if (q_data.size() > 0 && !req_ready_out) stalls++;
    if (m_pop) begin
      void'(q_data.pop_front());
      void'(q_sel.pop_front());
    end
    if (m_grant >= 0) begin
      q_data.push_back(req_data_in[m_grant*DW +: DW]);
      q_sel.push_back(m_grant);
      rr = (m_grant + 1) % N;
    end
  endtask

  // call at negedge with inputs already driven; returns at next negedge
  task automatic cycle();
    #1;
    compare();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic zero_outputs(input string nm);
    chk({nm, "_valid"}, 64'(req_valid_out), 64'd0);
    chk({nm, "_data"}, 64'(req_data_out), 64'd0);
    chk({nm, "_sel"}, 64'(req_sel_out), 64'd0);
    chk({nm, "_perf"}, 64'(perf_stalls_out), 64'd0);
    chk({nm, "_ready_in"}, 64'(req_ready_in), 64'd0);
  endtask

  task automatic do_reset(input string nm);
    reset_n = 1'b0;
    #1;
    zero_outputs(nm);
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    model_clear();
  endtask

  task automatic set_src(input int i, input logic [DW-1:0] d);
    req_data_in[i*DW +: DW] = d;
  endtask

  int grants;

  initial begin
    reset_n       = 1'b0;
    req_valid_in  = '0;
    req_data_in   = '0;
    req_ready_out = 1'b0;
    model_clear();
    @(negedge clk);
    req_valid_in = 4'b1111;
    do_reset("reset");

    // lone source 2
    req_valid_in  = 4'b0100;
    req_ready_out = 1'b1;
    set_src(2, 32'hA5);
    #1;
    chk("src2_ready_in", 64'(req_ready_in), 64'b0100);
    cycle();
    req_valid_in = '0;
    #1;
    chk("src2_valid", 64'(req_valid_out), 64'd1);
    chk("src2_data", 64'(req_data_out), 64'hA5);
    chk("src2_sel", 64'(req_sel_out), 64'd2);
    cycle();

    // all sources streaming
    do_reset("reset_rr");
    req_valid_in  = 4'b1111;
    req_ready_out = 1'b1;
    for (int i = 0; i < N; i++) set_src(i, DW'(32'h100 + i));
    cycle();
    for (int c = 0; c < 8; c++) begin
      #1;
      chk("rr_valid", 64'(req_valid_out), 64'd1);
      chk("rr_sel", 64'(req_sel_out), 64'(c % 4));
      cycle();
    end

    // back-pressure fills the buffer
    do_reset("reset_stall");
    req_valid_in  = 4'b0011;
    req_ready_out = 1'b0;
    set_src(0, 32'hD0);
    set_src(1, 32'hD1);
    grants = 0;
    for (int c = 0; c < 6; c++) begin
      #1;
      grants += $countones(req_ready_in);
      cycle();
    end
    #1;
    chk("stall_grants", 64'(grants), 64'd2);
    chk("stall_ready_in", 64'(req_ready_in), 64'd0);
    chk("stall_perf", 64'(perf_stalls_out), 64'd5);
    chk("stall_head", 64'(req_data_out), 64'hD0);

    // drain from FULL
    req_ready_out = 1'b1;
    cycle();
    #1;
    chk("drain_head2", 64'(req_data_out), 64'hD1);
    chk("drain_sel2", 64'(req_sel_out), 64'd1);
    for (int c = 0; c < 6; c++) cycle();

    // refill, then reset while FULL
    req_ready_out = 1'b0;
    for (int c = 0; c < 3; c++) cycle();
    #1;
    chk("full_before_reset", 64'(req_ready_in), 64'd0);
    do_reset("reset_full");
    req_valid_in  = 4'b1010;
    req_ready_out = 1'b1;
    cycle();
    #1;
    chk("post_reset_sel", 64'(req_sel_out), 64'd1);
    cycle();

    // long stall saturates narrow counter
    do_reset("reset_sat");
    req_valid_in  = 4'b0001;
    req_ready_out = 1'b0;
    for (int c = 0; c < 21; c++) cycle();
    #1;
    chk("sat_perf4", 64'(perf4), 64'd15);
    chk("sat_perf32", 64'(perf_stalls_out), 64'd20);

    // randomized soak
    do_reset("reset_rand");
    for (int c = 0; c < 3000; c++) begin
      req_valid_in = N'($urandom_range(0, 15));
      for (int i = 0; i < N; i++) set_src(i, DW'($urandom));
      if (c < 1000)
        req_ready_out = ($urandom_range(0, 3) != 0);
      else if (c < 2000)
        req_ready_out = ($urandom_range(0, 3) == 0);
      else
        req_ready_out = $urandom_range(0, 1) != 0;
      if ($urandom_range(0, 299) == 0) begin
        #3;
        do_reset("reset_async");
      end else begin
        cycle();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
